// File: rtl/cv32e40p_hwloop_sequencer.sv
// Hardware-loop sequencer: converts loop-setup commands into register-file writes,
// picks the innermost loop to decrement on a loop-end retire and requests the jump back.
module cv32e40p_hwloop_sequencer #(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    setup_valid_i,
    output logic                    setup_ready_o,
    input  logic [N_REG_BITS-1:0]   setup_regid_i,
    input  logic [2:0]              setup_mask_i,
    input  logic [31:0]             setup_start_i,
    input  logic [31:0]             setup_end_i,
    input  logic [31:0]             setup_cnt_i,

    output logic [2:0]              hwlp_we_o,
    output logic [N_REG_BITS-1:0]   hwlp_regid_o,
    output logic [31:0]             hwlp_start_data_o,
    output logic [31:0]             hwlp_end_data_o,
    output logic [31:0]             hwlp_cnt_data_o,

    input  logic [N_REGS-1:0][31:0] hwlp_start_addr_i,
    input  logic [N_REGS-1:0][31:0] hwlp_end_addr_i,
    input  logic [N_REGS-1:0][31:0] hwlp_counter_i,

    input  logic [31:0]             instr_addr_i,
    input  logic                    instr_retire_i,
    output logic [N_REGS-1:0]       hwlp_dec_cnt_o,
    output logic                    hwlp_valid_o,

    output logic                    jump_req_o,
    output logic [31:0]             jump_target_o,
    input  logic                    jump_ack_i,

    output logic                    busy_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        SETTLE    = 2'd2,
        JUMP_PEND = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [N_REG_BITS-1:0]   regid_q, regid_d;
    logic [2:0]              mask_q, mask_d;
    logic [31:0]             start_q, start_d;
    logic [31:0]             end_q, end_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [31:0]             jump_target_q, jump_target_d;

    logic                    match_found;
    logic [N_REG_BITS-1:0]   win_idx;

    // Lowest index wins: loop 0 is the innermost and must be serviced first.
    always_comb begin
        match_found = 1'b0;
        win_idx     = '0;
        for (int k = 0; k < N_REGS; k++) begin
            if (!match_found && instr_retire_i &&
                (instr_addr_i == hwlp_end_addr_i[k]) && (hwlp_counter_i[k] != 32'd0)) begin
                match_found = 1'b1;
                win_idx     = N_REG_BITS'(k);
            end
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d           = state_q;
        regid_d           = regid_q;
        mask_d            = mask_q;
        start_d           = start_q;
        end_d             = end_q;
        cnt_d             = cnt_q;
        jump_target_d     = jump_target_q;
        setup_ready_o     = 1'b0;
        hwlp_dec_cnt_o    = '0;
        hwlp_valid_o      = 1'b0;
        hwlp_we_o         = 3'b000;
        hwlp_regid_o      = '0;
        hwlp_start_data_o = 32'd0;
        hwlp_end_data_o   = 32'd0;
        hwlp_cnt_data_o   = 32'd0;
        jump_req_o        = 1'b0;

        case (state_q)
            IDLE: begin
                hwlp_valid_o  = instr_retire_i;
                setup_ready_o = !match_found;
                if (match_found) begin
                    hwlp_dec_cnt_o[win_idx] = 1'b1;
                    // A count of one only decrements to zero; anything larger loops back.
                    if (hwlp_counter_i[win_idx] > 32'd1) begin
                        jump_target_d = hwlp_start_addr_i[win_idx];
                        state_d       = JUMP_PEND;
                    end
                end else if (setup_valid_i) begin
                    regid_d = setup_regid_i;
                    mask_d  = setup_mask_i;
                    start_d = setup_start_i;
                    end_d   = setup_end_i;
                    cnt_d   = setup_cnt_i;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                hwlp_we_o         = mask_q;
                hwlp_regid_o      = regid_q;
                hwlp_start_data_o = start_q;
                hwlp_end_data_o   = end_q;
                hwlp_cnt_data_o   = cnt_q;
                state_d           = SETTLE;
            end
            SETTLE: begin
                // Register file updates this cycle; compares resume in IDLE.
                state_d = IDLE;
            end
            JUMP_PEND: begin
                jump_req_o = 1'b1;
                if (jump_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            regid_q       <= '0;
            mask_q        <= 3'b000;
            start_q       <= 32'd0;
            end_q         <= 32'd0;
            cnt_q         <= 32'd0;
            jump_target_q <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q       <= state_d;
            regid_q       <= regid_d;
            mask_q        <= mask_d;
            start_q       <= start_d;
            end_q         <= end_d;
            cnt_q         <= cnt_d;
            jump_target_q <= jump_target_d;
        end
    end

    assign jump_target_o = jump_target_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_cv32e40p_hwloop_sequencer.sv
// Bench for cv32e40p_hwloop_sequencer: a transaction-level loop model predicts writes,
// decrements and jumps; a negedge monitor scoreboards what the DUT actually presents.
module tb_cv32e40p_hwloop_sequencer;

    localparam int N_REGS     = 2;
    localparam int N_REG_BITS = $clog2(N_REGS);

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    setup_valid_i;
    logic                    setup_ready_o;
    logic [N_REG_BITS-1:0]   setup_regid_i;
    logic [2:0]              setup_mask_i;
    logic [31:0]             setup_start_i, setup_end_i, setup_cnt_i;
    logic [2:0]              hwlp_we_o;
    logic [N_REG_BITS-1:0]   hwlp_regid_o;
    logic [31:0]             hwlp_start_data_o, hwlp_end_data_o, hwlp_cnt_data_o;
    logic [31:0]             instr_addr_i;
    logic                    instr_retire_i;
    logic [N_REGS-1:0]       hwlp_dec_cnt_o;
    logic                    hwlp_valid_o;
    logic                    jump_req_o;
    logic [31:0]             jump_target_o;
    logic                    jump_ack_i;
    logic                    busy_o;

    // Register file that the sequencer controls; it lives in the environment.
    logic [N_REGS-1:0][31:0] rf_start = '0;
    logic [N_REGS-1:0][31:0] rf_end   = '0;
    logic [N_REGS-1:0][31:0] rf_cnt   = '0;

    always #5 clk = ~clk;

    cv32e40p_hwloop_sequencer #(.N_REGS(N_REGS)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .setup_valid_i     (setup_valid_i),
        .setup_ready_o     (setup_ready_o),
        .setup_regid_i     (setup_regid_i),
        .setup_mask_i      (setup_mask_i),
        .setup_start_i     (setup_start_i),
        .setup_end_i       (setup_end_i),
        .setup_cnt_i       (setup_cnt_i),
        .hwlp_we_o         (hwlp_we_o),
        .hwlp_regid_o      (hwlp_regid_o),
        .hwlp_start_data_o (hwlp_start_data_o),
        .hwlp_end_data_o   (hwlp_end_data_o),
        .hwlp_cnt_data_o   (hwlp_cnt_data_o),
        .hwlp_start_addr_i (rf_start),
        .hwlp_end_addr_i   (rf_end),
        .hwlp_counter_i    (rf_cnt),
        .instr_addr_i      (instr_addr_i),
        .instr_retire_i    (instr_retire_i),
        .hwlp_dec_cnt_o    (hwlp_dec_cnt_o),
        .hwlp_valid_o      (hwlp_valid_o),
        .jump_req_o        (jump_req_o),
        .jump_target_o     (jump_target_o),
        .jump_ack_i        (jump_ack_i),
        .busy_o            (busy_o)
    );

    always @(posedge clk) begin
        if (hwlp_we_o[0]) rf_start[hwlp_regid_o] <= hwlp_start_data_o;
        if (hwlp_we_o[1]) rf_end[hwlp_regid_o]   <= hwlp_end_data_o;
        if (hwlp_we_o[2]) rf_cnt[hwlp_regid_o]   <= hwlp_cnt_data_o;
        if (hwlp_valid_o) begin
            for (int k = 0; k < N_REGS; k++)
                if (hwlp_dec_cnt_o[k]) rf_cnt[k] <= rf_cnt[k] - 32'd1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {EV_WRITE, EV_DEC} ev_kind_e;
    typedef struct {
        ev_kind_e                kind;
        logic [N_REG_BITS-1:0]   regid;
        logic [2:0]              mask;
        logic [31:0]             start;
        logic [31:0]             end_a;
        logic [31:0]             cnt;
        logic [N_REGS-1:0]       onehot;
        bit                      jump;
        logic [31:0]             target;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] m_start [N_REGS];
    logic [31:0] m_end   [N_REGS];
    logic [31:0] m_cnt   [N_REGS];

    task automatic model_setup(input logic [N_REG_BITS-1:0] id, input logic [2:0] m,
                               input logic [31:0] s, input logic [31:0] e, input logic [31:0] c);
        ev_t ev;
        ev.kind = EV_WRITE; ev.regid = id; ev.mask = m;
        ev.start = s; ev.end_a = e; ev.cnt = c;
        ev.onehot = '0; ev.jump = 1'b0; ev.target = 32'd0;
        if (m != 3'b000) exp_q.push_back(ev);
        if (m[0]) m_start[id] = s;
        if (m[1]) m_end[id]   = e;
        if (m[2]) m_cnt[id]   = c;
    endtask

    task automatic model_retire(input logic [31:0] addr, output bit hit);
        ev_t ev;
        hit = 1'b0;
        for (int k = 0; k < N_REGS; k++) begin
            if (!hit && addr == m_end[k] && m_cnt[k] != 0) begin
                hit = 1'b1;
                ev.kind = EV_DEC; ev.regid = '0; ev.mask = 3'b000;
                ev.start = 32'd0; ev.end_a = 32'd0; ev.cnt = 32'd0;
                ev.onehot = '0; ev.onehot[k] = 1'b1;
                ev.jump = (m_cnt[k] > 1);
                ev.target = m_start[k];
                exp_q.push_back(ev);
                m_cnt[k] = m_cnt[k] - 1;
            end
        end
    endtask

    // ---------------- fetch-side ack responder ----------------
    int ack_delay_cfg = 0;

    initial begin
        int ack_wait;
        ack_wait   = 0;
        jump_ack_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (jump_req_o && !jump_ack_i) begin
                if (ack_wait == 0) jump_ack_i = 1'b1;
                else ack_wait--;
            end else begin
                jump_ack_i = 1'b0;
                ack_wait   = ack_delay_cfg;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit          jump_due, jump_active, nojump_due, ack_seen;
        logic [31:0] cur_target;
        ev_t         ev;
        jump_due = 0; jump_active = 0; nojump_due = 0; ack_seen = 0; cur_target = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                jump_due = 0; jump_active = 0; nojump_due = 0; ack_seen = 0;
            end else begin
                if (jump_due) begin
                    check("jump req latency", jump_req_o, 1);
                    check("jump target", jump_target_o, cur_target);
                    jump_due = 0; jump_active = 1;
                end else if (jump_active) begin
                    if (ack_seen) begin
                        check("jump req drop after ack", jump_req_o, 0);
                        jump_active = 0; ack_seen = 0;
                    end else begin
                        check("jump req hold", jump_req_o, 1);
                        check("jump target hold", jump_target_o, cur_target);
                    end
                end else if (nojump_due) begin
                    check("no jump on last iteration", jump_req_o, 0);
                    nojump_due = 0;
                end else if (jump_req_o) begin
                    check("unexpected jump req", jump_req_o, 0);
                end
                if (jump_active && jump_ack_i) ack_seen = 1;

                if (!instr_retire_i) check("valid without retire", hwlp_valid_o, 0);

                if (hwlp_we_o != 3'b000) begin
                    if (exp_q.size() == 0 || exp_q[0].kind != EV_WRITE) begin
                        check("unexpected write", {29'd0, hwlp_we_o}, 0);
                    end else begin
                        ev = exp_q.pop_front();
                        check("write we", {29'd0, hwlp_we_o}, {29'd0, ev.mask});
                        check("write regid", 32'(hwlp_regid_o), 32'(ev.regid));
                        check("write start", hwlp_start_data_o, ev.start);
                        check("write end", hwlp_end_data_o, ev.end_a);
                        check("write cnt", hwlp_cnt_data_o, ev.cnt);
                    end
                end

                if (hwlp_dec_cnt_o != '0) begin
                    if (exp_q.size() == 0 || exp_q[0].kind != EV_DEC) begin
                        check("unexpected decrement", 32'(hwlp_dec_cnt_o), 0);
                    end else begin
                        ev = exp_q.pop_front();
                        check("decrement select", 32'(hwlp_dec_cnt_o), 32'(ev.onehot));
                        check("decrement valid", hwlp_valid_o, 1);
                        if (ev.jump) begin
                            jump_due = 1; cur_target = ev.target;
                        end else begin
                            nojump_due = 1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy_o || jump_req_o) && n < 50);
        check("idle within budget", {31'd0, busy_o | jump_req_o}, 0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!setup_ready_o && n < 50);
        check("setup ready within budget", setup_ready_o, 1);
    endtask

    task automatic post_setup_checks(input logic [2:0] m);
        @(negedge clk);
        check("write busy", busy_o, 1);
        check("write ready low", setup_ready_o, 0);
        check("write cycle we", {29'd0, hwlp_we_o}, {29'd0, m});
        @(negedge clk);
        check("settle busy", busy_o, 1);
        check("settle ready low", setup_ready_o, 0);
        check("settle we", {29'd0, hwlp_we_o}, 0);
        check("settle data zero", hwlp_start_data_o | hwlp_end_data_o | hwlp_cnt_data_o, 0);
        @(negedge clk);
        check("idle after settle", busy_o, 0);
        check("ready after settle", setup_ready_o, 1);
        check("idle data zero", hwlp_start_data_o | hwlp_end_data_o | hwlp_cnt_data_o, 0);
    endtask

    task automatic drive_setup_fields(input logic [N_REG_BITS-1:0] id, input logic [2:0] m,
                                      input logic [31:0] s, input logic [31:0] e, input logic [31:0] c);
        setup_regid_i = id; setup_mask_i = m;
        setup_start_i = s; setup_end_i = e; setup_cnt_i = c;
        setup_valid_i = 1'b1;
    endtask

    task automatic do_setup(input logic [N_REG_BITS-1:0] id, input logic [2:0] m,
                            input logic [31:0] s, input logic [31:0] e, input logic [31:0] c);
        model_setup(id, m, s, e, c);
        @(posedge clk); #1;
        drive_setup_fields(id, m, s, e, c);
        wait_ready();
        @(posedge clk); #1;
        setup_valid_i = 1'b0;
        post_setup_checks(m);
    endtask

    task automatic do_retire(input logic [31:0] addr, input int ack_dly);
        bit hit;
        ack_delay_cfg = ack_dly;
        model_retire(addr, hit);
        @(posedge clk); #1;
        instr_retire_i = 1'b1;
        instr_addr_i   = addr;
        @(negedge clk);
        check("retire valid", hwlp_valid_o, 1);
        check("ready vs loop end", setup_ready_o, {31'd0, !hit});
        @(posedge clk); #1;
        instr_retire_i = 1'b0;
        wait_idle();
        check("scoreboard drained", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit          hit;
        logic [31:0] a;
        for (int k = 0; k < N_REGS; k++) begin
            m_start[k] = 32'd0; m_end[k] = 32'd0; m_cnt[k] = 32'd0;
        end
        rst_n = 1'b0;
        setup_valid_i = 1'b0; setup_regid_i = '0; setup_mask_i = 3'b000;
        setup_start_i = 32'd0; setup_end_i = 32'd0; setup_cnt_i = 32'd0;
        instr_addr_i = 32'd0; instr_retire_i = 1'b0;

        repeat (2) @(negedge clk);
        check("reset ready", setup_ready_o, 1);
        check("reset busy", busy_o, 0);
        check("reset jump req", jump_req_o, 0);
        check("reset jump target", jump_target_o, 0);
        check("reset we", {29'd0, hwlp_we_o}, 0);
        check("reset dec", 32'(hwlp_dec_cnt_o), 0);
        check("reset valid", hwlp_valid_o, 0);
        check("reset data", hwlp_start_data_o | hwlp_end_data_o | hwlp_cnt_data_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full setup of loop 1.
        do_setup(1, 3'b111, 32'h100, 32'h120, 32'd3);

        // Loop 0 with two iterations: first retire jumps (slow ack), second only decrements.
        do_setup(0, 3'b111, 32'h200, 32'h210, 32'd2);
        do_retire(32'h210, 3);
        do_retire(32'h210, 0);

        // Shared end address: innermost loop wins; ack on the first request cycle.
        do_setup(0, 3'b111, 32'h280, 32'h300, 32'd5);
        do_setup(1, 3'b111, 32'h2C0, 32'h300, 32'd4);
        do_retire(32'h300, 0);

        // Setup offered in the same cycle as a loop-end retire.
        ack_delay_cfg = 2;
        model_retire(32'h300, hit);
        model_setup(1, 3'b101, 32'h700, 32'h0, 32'd2);
        @(posedge clk); #1;
        instr_retire_i = 1'b1;
        instr_addr_i   = 32'h300;
        drive_setup_fields(1, 3'b101, 32'h700, 32'h0, 32'd2);
        @(negedge clk);
        check("ready blocked by loop end", setup_ready_o, 0);
        @(posedge clk); #1;
        instr_retire_i = 1'b0;
        wait_idle();
        check("setup taken first idle cycle", setup_ready_o, 1);
        @(posedge clk); #1;
        setup_valid_i = 1'b0;
        post_setup_checks(3'b101);
        check("combined drained", exp_q.size(), 0);

        // Zero count never matches; mask==0 passes through without writing.
        do_setup(1, 3'b110, 32'h0, 32'h400, 32'd0);
        do_retire(32'h400, 0);
        do_setup(0, 3'b000, 32'hDEAD_BEEF, 32'h400, 32'd7);
        do_retire(32'h400, 0);

        // Reset while a jump is pending.
        do_setup(0, 3'b111, 32'h600, 32'h610, 32'd4);
        ack_delay_cfg = 1000;
        model_retire(32'h610, hit);
        @(posedge clk); #1;
        instr_retire_i = 1'b1;
        instr_addr_i   = 32'h610;
        @(posedge clk); #1;
        instr_retire_i = 1'b0;
        @(negedge clk);
        check("pending before reset", jump_req_o, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("reset drops jump req", jump_req_o, 0);
        check("reset clears busy", busy_o, 0);
        check("reset clears target", jump_target_o, 0);
        check("reset ready", setup_ready_o, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_delay_cfg = 0;
        @(negedge clk);
        check("post-reset idle", busy_o, 0);
        check("post-reset ready", setup_ready_o, 1);
        check("post-reset no jump", jump_req_o, 0);
        check("post-reset drained", exp_q.size(), 0);

        // Randomized mix of setups and retires over a small, colliding address set.
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_setup(N_REG_BITS'($urandom_range(0, N_REGS - 1)), 3'($urandom_range(0, 7)),
                         $urandom & 32'hFFFF_FFFC,
                         32'h1000 + 32'($urandom_range(0, 2)) * 32'd16,
                         32'($urandom_range(0, 4)));
            end else begin
                if ($urandom_range(0, 4) == 0) a = 32'h1030;
                else a = m_end[$urandom_range(0, N_REGS - 1)];
                do_retire(a, $urandom_range(0, 3));
            end
        end

        repeat (5) @(negedge clk);
        check("final drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
